// File: rtl/bram1_stream.sv
// Burst sequencer driving a one-cycle-latency single-port BRAM for a streaming client.
// Write bursts go straight through to the RAM; read bursts return through a 2-entry output FIFO.
module bram1_stream #(
  parameter int Ncells = 1024,
  parameter int Wdata  = 8,
  parameter int Wlen   = $clog2(Ncells) + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic                      CMD_WR,
  input  logic [$clog2(Ncells)-1:0] CMD_ADDR,
  input  logic [Wlen-1:0]           CMD_LEN,
  input  logic [Wdata-1:0]          WDATA,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [Wdata-1:0]          RDATA,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      DONE,
  output logic [$clog2(Ncells)-1:0] MEM_ADDR,
  output logic [Wdata-1:0]          MEM_DIN,
  output logic                      MEM_WR,
  input  logic [Wdata-1:0]          MEM_DOUT
);

  localparam int AW = $clog2(Ncells);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t           state;
  state_t           next_state;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    next_addr;
  logic [Wlen-1:0]  remain;
  logic [Wlen-1:0]  pop_remain;
  logic             inflight;
  logic [Wdata-1:0] head;
  logic [Wdata-1:0] tail;
  logic             head_valid;
  logic             tail_valid;
  logic             cmd_take;
  logic             beat;
  logic             pop;
  logic             issue;
  logic [1:0]       occupancy;

  // Occupancy after this cycle; a read issued now lands in the FIFO next cycle.
  always_comb begin
    cmd_take   = (state == IDLE) && CMD_VALID;
    beat       = (state == WRITE) && WVALID;
    pop        = head_valid && RREADY;
    occupancy  = {1'b0, head_valid} + {1'b0, tail_valid} + {1'b0, inflight} - {1'b0, pop};
    issue      = (state == READ) && (remain != '0) && (occupancy < 2'd2);
    next_addr  = (addr == AW'(Ncells - 1)) ? '0 : addr + 1'b1;
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_take) begin
          if (CMD_LEN == '0)  next_state = FINISH;
          else if (CMD_WR)    next_state = WRITE;
          else                next_state = READ;
        end
      end
      WRITE:   if (beat && remain == Wlen'(1))     next_state = FINISH;
      READ:    if (pop && pop_remain == Wlen'(1))  next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state == IDLE) && !RST;
    WREADY    = (state == WRITE) && !RST;
    MEM_WR    = beat && !RST;
    MEM_DIN   = ((state == WRITE) && !RST) ? WDATA : '0;
    MEM_ADDR  = addr;
    RDATA     = head;
    RVALID    = head_valid && !RST;
    DONE      = (state == FINISH) && !RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr       <= '0;
      remain     <= '0;
      pop_remain <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
    end else begin
      state    <= next_state;
      inflight <= issue;
      if (cmd_take) begin
        addr       <= CMD_ADDR;
        remain     <= CMD_LEN;
        pop_remain <= CMD_LEN;
      end else begin
        if (beat || issue) begin
          addr   <= next_addr;
          remain <= remain - 1'b1;
        end
        if (pop) pop_remain <= pop_remain - 1'b1;
      end
      // RAM data is captured unconditionally the cycle after issue; the issue rule keeps room.
      if (pop) begin
        if (tail_valid) begin
          head       <= tail;
          tail_valid <= inflight;
          if (inflight) tail <= MEM_DOUT;
        end else begin
          head_valid <= inflight;
          if (inflight) head <= MEM_DOUT;
        end
      end else if (inflight) begin
        if (!head_valid) begin
          head       <= MEM_DOUT;
          head_valid <= 1'b1;
        end else begin
          tail       <= MEM_DOUT;
          tail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram1_stream.sv
// Self-checking bench for bram1_stream: behavioural RAM plus an array model of expected contents.
// Bursts use random data/addresses; expected beats come from (addr + k) mod Ncells arithmetic.
module tb_bram1_stream;

  localparam int Ncells = 1024;
  localparam int Wdata  = 8;
  localparam int Wlen   = 11;
  localparam int AW     = 10;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic             CMD_WR;
  logic [AW-1:0]    CMD_ADDR;
  logic [Wlen-1:0]  CMD_LEN;
  logic [Wdata-1:0] WDATA;
  logic             WVALID;
  logic             WREADY;
  logic [Wdata-1:0] RDATA;
  logic             RVALID;
  logic             RREADY;
  logic             DONE;
  logic [AW-1:0]    MEM_ADDR;
  logic [Wdata-1:0] MEM_DIN;
  logic             MEM_WR;
  logic [Wdata-1:0] MEM_DOUT;

  logic [Wdata-1:0] ram       [Ncells];
  logic [Wdata-1:0] model_mem [Ncells];

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bram1_stream #(.Ncells(Ncells), .Wdata(Wdata), .Wlen(Wlen)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .DONE(DONE),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_WR(MEM_WR), .MEM_DOUT(MEM_DOUT)
  );

  // One-cycle-latency single-port RAM seen by the DUT.
  always @(posedge CLK) begin
    if (MEM_WR) ram[MEM_ADDR] <= MEM_DIN;
    MEM_DOUT <= ram[MEM_ADDR];
  end

  task automatic do_write(input int a, input int len, input int mode, input string tag);
    bit               pat [6] = '{1, 0, 1, 1, 0, 1};
    int               k;
    int               cyc;
    int               exp_addr;
    logic             v;
    logic [Wdata-1:0] wd;
    CMD_VALID = 1'b1; CMD_WR = 1'b1; CMD_ADDR = AW'(a); CMD_LEN = Wlen'(len);
    #1;
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++; $display("[TB] FAIL %s cmd_ready got=%b want=1", tag, CMD_READY);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    k = 0; cyc = 0;
    while (k < len && cyc < len * 10 + 20) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[cyc % 6];
        default: v = 1'($urandom_range(0, 1));
      endcase
      wd = Wdata'($urandom);
      WVALID = v; WDATA = wd;
      #1;
      exp_addr = (a + k) % Ncells;
      checks++;
      if (MEM_WR !== v || DONE !== 1'b0) begin
        failures++; $display("[TB] FAIL %s mem_wr/done got=%b/%b want=%b/0", tag, MEM_WR, DONE, v);
      end
      if (v) begin
        checks++;
        if (MEM_ADDR !== AW'(exp_addr) || MEM_DIN !== wd || WREADY !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s beat%0d addr/din/wready got=%0d/%h/%b want=%0d/%h/1",
                   tag, k, MEM_ADDR, MEM_DIN, WREADY, exp_addr, wd);
        end
        model_mem[exp_addr] = wd;
        k++;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    WVALID = 1'b0;
    if (k < len) begin
      checks++; failures++;
      $display("[TB] FAIL %s timeout beats got=%0d want=%0d", tag, k, len);
    end
    #1;
    checks++;
    if (DONE !== 1'b1 || MEM_WR !== 1'b0) begin
      failures++; $display("[TB] FAIL %s done_pulse done/mem_wr got=%b/%b want=1/0", tag, DONE, MEM_WR);
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0 || CMD_READY !== 1'b1 || WREADY !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s after_done done/cmd_ready/wready got=%b/%b/%b want=0/1/0",
               tag, DONE, CMD_READY, WREADY);
    end
  endtask

  task automatic do_read(input int a, input int len, input int mode, input string tag);
    bit               pat [6] = '{1, 0, 0, 1, 0, 1};
    int               popped;
    int               cyc;
    int               first;
    logic             r;
    logic             prev_stall;
    logic [Wdata-1:0] prev_data;
    logic [Wdata-1:0] exp_data;
    CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADDR = AW'(a); CMD_LEN = Wlen'(len);
    #1;
    checks++;
    if (CMD_READY !== 1'b1) begin
      failures++; $display("[TB] FAIL %s cmd_ready got=%b want=1", tag, CMD_READY);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    popped = 0; cyc = 1; first = -1; prev_stall = 1'b0; prev_data = '0;
    while (popped < len && cyc < len * 10 + 20) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[(cyc - 1) % 6];
        default: r = 1'($urandom_range(0, 1));
      endcase
      RREADY = r;
      #1;
      checks++;
      if (MEM_WR !== 1'b0 || DONE !== 1'b0) begin
        failures++; $display("[TB] FAIL %s mem_wr/done got=%b/%b want=0/0", tag, MEM_WR, DONE);
      end
      if (prev_stall) begin
        checks++;
        if (RVALID !== 1'b1 || RDATA !== prev_data) begin
          failures++;
          $display("[TB] FAIL %s stall_hold rvalid/rdata got=%b/%h want=1/%h", tag, RVALID, RDATA, prev_data);
        end
      end
      if (RVALID === 1'b1) begin
        if (first < 0) first = cyc;
        if (r) begin
          exp_data = model_mem[(a + popped) % Ncells];
          checks++;
          if (RDATA !== exp_data) begin
            failures++; $display("[TB] FAIL %s beat%0d rdata got=%h want=%h", tag, popped, RDATA, exp_data);
          end
          popped++;
        end
      end
      prev_stall = (RVALID === 1'b1) && !r;
      prev_data  = RDATA;
      @(posedge CLK); #1;
      cyc++;
    end
    RREADY = 1'b0;
    if (popped < len) begin
      checks++; failures++;
      $display("[TB] FAIL %s timeout beats got=%0d want=%0d", tag, popped, len);
    end
    #1;
    checks++;
    if (DONE !== 1'b1 || RVALID !== 1'b0) begin
      failures++; $display("[TB] FAIL %s done_pulse done/rvalid got=%b/%b want=1/0", tag, DONE, RVALID);
    end
    if (mode == 0 && len > 0) begin
      checks++;
      if (first !== 3 || cyc !== len + 3) begin
        failures++;
        $display("[TB] FAIL %s latency first_rvalid/done got=c+%0d/c+%0d want=c+3/c+%0d", tag, first, cyc, len + 3);
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0 || RVALID !== 1'b0 || CMD_READY !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s after_done done/rvalid/cmd_ready got=%b/%b/%b want=0/0/1",
               tag, DONE, RVALID, CMD_READY);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (CMD_READY !== 1'b0 || RVALID !== 1'b0 || DONE !== 1'b0 || WREADY !== 1'b0 || MEM_WR !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_during cmd_ready/rvalid/done/wready/mem_wr got=%b/%b/%b/%b/%b want=0/0/0/0/0",
               CMD_READY, RVALID, DONE, WREADY, MEM_WR);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (CMD_READY !== 1'b1 || RVALID !== 1'b0 || DONE !== 1'b0 || WREADY !== 1'b0 ||
        MEM_WR !== 1'b0 || MEM_ADDR !== '0 || RDATA !== '0) begin
      failures++;
      $display("[TB] FAIL reset_after cmd_ready/rvalid/done/wready/mem_wr/addr/rdata got=%b/%b/%b/%b/%b/%0d/%h",
               CMD_READY, RVALID, DONE, WREADY, MEM_WR, MEM_ADDR, RDATA);
    end
  endtask

  task automatic test_wrap_write;
    do_write(1022, 4, 0, "wrap_write");
  endtask

  task automatic test_full_read;
    do_read(1022, 4, 0, "full_read");
  endtask

  task automatic test_read_backpressure;
    do_read(1022, 4, 1, "read_backpressure");
  endtask

  task automatic test_write_gaps;
    int a;
    a = $urandom_range(0, Ncells - 1);
    do_write(a, 4, 1, "write_gaps");
    do_read(a, 4, 0, "write_gaps_readback");
  endtask

  task automatic test_zero_len;
    do_write($urandom_range(0, Ncells - 1), 0, 0, "zero_len_write");
    do_read($urandom_range(0, Ncells - 1), 0, 0, "zero_len_read");
  endtask

  task automatic test_mid_reset;
    int a;
    int popped;
    int cyc;
    logic [Wdata-1:0] exp_data;
    a = $urandom_range(0, Ncells - 1);
    CMD_VALID = 1'b1; CMD_WR = 1'b0; CMD_ADDR = AW'(a); CMD_LEN = Wlen'(8);
    #1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; RREADY = 1'b1;
    popped = 0; cyc = 0;
    while (popped < 2 && cyc < 20) begin
      #1;
      if (RVALID === 1'b1) begin
        exp_data = model_mem[(a + popped) % Ncells];
        checks++;
        if (RDATA !== exp_data) begin
          failures++; $display("[TB] FAIL mid_reset beat%0d rdata got=%h want=%h", popped, RDATA, exp_data);
        end
        popped++;
      end
      @(posedge CLK); #1;
      cyc++;
    end
    if (popped < 2) begin
      checks++; failures++; $display("[TB] FAIL mid_reset timeout beats got=%0d want=2", popped);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (CMD_READY !== 1'b0 || MEM_WR !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset during cmd_ready/mem_wr got=%b/%b want=0/0", CMD_READY, MEM_WR);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0 || CMD_READY !== 1'b1 || DONE !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset after rvalid/cmd_ready/done got=%b/%b/%b want=0/1/0", RVALID, CMD_READY, DONE);
    end
    repeat (12) begin
      @(posedge CLK); #1;
      checks++;
      if (DONE !== 1'b0 || RVALID !== 1'b0 || MEM_WR !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mid_reset quiet done/rvalid/mem_wr got=%b/%b/%b want=0/0/0", DONE, RVALID, MEM_WR);
      end
    end
    RREADY = 1'b0;
    a = $urandom_range(0, Ncells - 1);
    do_write(a, 5, 0, "post_reset_write");
    do_read(a, 5, 0, "post_reset_read");
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, Ncells - 1), $urandom_range(0, 40), 2, "random_write");
      else
        do_read($urandom_range(0, Ncells - 1), $urandom_range(0, 40), 2, "random_read");
    end
  endtask

  task automatic test_long_wrap;
    int a;
    a = $urandom_range(0, Ncells - 1);
    do_write(a, 1030, 0, "long_write");
    do_read(a, 1030, 2, "long_read");
  endtask

  initial begin
    for (int i = 0; i < Ncells; i++) begin
      ram[i]       = Wdata'($urandom);
      model_mem[i] = ram[i];
    end
    RST = 1'b1; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
    WDATA = '0; WVALID = 1'b0; RREADY = 1'b0;
    test_reset;
    test_wrap_write;
    test_full_read;
    test_read_backpressure;
    test_write_gaps;
    test_zero_len;
    test_mid_reset;
    test_random;
    test_long_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
